asian_payoff_acc: RTL and testbench
===================================

// Module: asian_payoff_acc
// PURPOSE
//   Downstream consumer of the path generator's output stream.
//   - Takes DAY-sample price paths, forms each path's arithmetic average, and computes the
//     Asian call payoff max(avg - K, 0).
//   - Accumulates payoffs over N_PATH paths and emits one 12-bit Monte-Carlo price.
//   - If the stream stalls mid-path, it discards the partial path and pulses resend so the
//     controller replays that path.
// PARAMETERS
//   DAY      8    samples per path; power of two, >=2
//   N_PATH   256  paths per price; power of two, >=2
//   DW       12   sample / strike / price width (unsigned)
//   TIMEOUT  16   idle cycles allowed between samples of one path before resend
// PORTS
//   clk          in   1   single clock; all logic on posedge
//   rst          in   1   synchronous, active-high reset
//   start        in   1   1-cycle pulse: clear accumulators, begin a new price run
//   K            in   DW  strike; sampled on the start cycle, held internally
//   in_valid     in   1   in_sample valid this cycle
//   in_sample    in   DW  path sample, unsigned
//   resend       out  1   1-cycle pulse: current partial path discarded, replay it
//   busy         out  1   high from the cycle after start until price_valid rises
//   price_valid  out  1   final price available; held until next start or rst
//   price        out  DW  average payoff over N_PATH paths
// BEHAVIOUR
//   Interface
//   - One clock `clk`; reset `rst` is synchronous and active-high.
//   - rst=1 at a posedge sets state=IDLE and clears all counters and accumulators.
//   - Reset outputs: resend=0, busy=0, price_valid=0, price=0.
//   FSM: IDLE -> COLLECT -> FLUSH -> DONE
//   - IDLE: in_valid ignored. On start: latch K, clear sums/counters, go to COLLECT.
//   - COLLECT: on each in_valid, path_sum += in_sample and day_cnt++.
//     - When the DAY-th sample is accepted:
//       - register avg = path_sum_final >> log2(DAY) (truncate);
//       - next cycle, payoff = (avg > K) ? avg - K : 0, with avg == K giving 0;
//         acc += payoff; path_cnt++.
//       - day_cnt and path_sum clear in the same cycle the DAY-th sample is accepted, so a
//         back-to-back next path with no bubble is accepted.
//     - After the N_PATH-th path's DAY-th sample, go to FLUSH.
//   - FLUSH: wait for the payoff pipeline to drain (2 cycles), then go to DONE.
//   - DONE: price = acc >> log2(N_PATH) (truncate); price_valid=1; busy=0.
//     Stay in DONE until start or rst.
//   Latency
//   - Last sample accepted at posedge t -> price_valid=1 and price valid at posedge t+3.
//   Stall / resend
//   - idle_cnt counts consecutive cycles with in_valid=0 while 0 < day_cnt < DAY.
//   - When idle_cnt reaches TIMEOUT:
//     - resend=1 for exactly one cycle;
//     - path_sum and day_cnt clear;
//     - path_cnt and acc are unchanged.
//   - idle_cnt resets on every in_valid. No timeout while day_cnt == 0, i.e. between paths.
//   Boundary conditions
//   - start in any state, including mid-run, aborts the run and restarts per the IDLE rule.
//   - start and in_valid in the same cycle: start wins and that sample is dropped.
//   - in_valid in FLUSH or DONE is ignored.
//   Widths
//   - path_sum is DW+log2(DAY) bits; acc is DW+log2(N_PATH) bits.
//   - Neither can overflow, so no saturation logic is needed.
// STRUCTURE
//   - Shared package: DAY, N_PATH, DW, TIMEOUT defaults; state encoding (IDLE/COLLECT/
//     FLUSH/DONE); widths derived via $clog2.
//   - Sub-module path_averager:
//     - contains day_cnt, path_sum, idle_cnt;
//     - outputs avg plus avg_valid (1-cycle) and timeout (1-cycle).
//   - The top holds the FSM, K latch, payoff compare/subtract, acc, path_cnt and output regs.
// TESTING (DAY=8, TIMEOUT=16; N_PATH=4 unless noted)
//   1. rst high 2 cycles mid-run, then low -> resend=0, busy=0, price_valid=0, price=0;
//      a new start is required.
//   2. K=1024, 4 paths all samples 2048, no bubbles -> price=1024, price_valid exactly
//      3 cycles after the 32nd sample.
//   3. K=4095, samples 4095 -> avg==K, payoff 0, price=0.
//   4. K=0, paths averaging 100/200/300/400 -> price=250.
//   5. Path 2 stalls 16 cycles after its 3rd sample -> single resend pulse; replay full
//      path 2 -> price identical to the no-stall run.
//   6. start pulsed after 2 paths, with a new K -> old sums discarded; price reflects only
//      the 4 new paths; also repeat test 2 with N_PATH=256 -> price=1024.

Source files
------------

// File: rtl/asian_payoff_acc_pkg.sv
// Shared defaults, state encoding and width helpers for the Asian payoff accumulator.
package asian_payoff_acc_pkg;

    localparam int DAY_D     = 8;
    localparam int N_PATH_D  = 256;
    localparam int DW_D      = 12;
    localparam int TIMEOUT_D = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_COLLECT = 2'd1;
    localparam state_t S_FLUSH   = 2'd2;
    localparam state_t S_DONE    = 2'd3;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/asian_payoff_acc_if.sv
// Control, sample-stream and result bundle between the path controller and the accumulator.
interface asian_payoff_acc_if #(
    parameter int DW = 12
);
    // i_in_valid qualifies i_in_sample for exactly one cycle; there is no backpressure,
    // so a sample presented while the accumulator is not collecting is simply dropped.
    logic          i_start;
    logic [DW-1:0] i_k;
    logic          i_in_valid;
    logic [DW-1:0] i_in_sample;
    logic          o_resend;
    logic          o_busy;
    logic          o_price_valid;
    logic [DW-1:0] o_price;
    logic [1:0]    o_state;

    modport master (
        output i_start, i_k, i_in_valid, i_in_sample,
        input  o_resend, o_busy, o_price_valid, o_price, o_state
    );

    modport slave (
        input  i_start, i_k, i_in_valid, i_in_sample,
        output o_resend, o_busy, o_price_valid, o_price, o_state
    );

endinterface

// File: rtl/asian_payoff_acc_path_averager.sv
// Sums DAY samples of one path, emits the truncated average, and flags a stalled partial path.
module asian_payoff_acc_path_averager
    import asian_payoff_acc_pkg::*;
#(
    parameter int DAY     = DAY_D,
    parameter int DW      = DW_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic [DW-1:0] i_sample,
    output logic          o_path_done,
    output logic [DW-1:0] o_avg,
    output logic          o_avg_valid,
    output logic          o_timeout
);
    localparam int LD = $clog2(DAY);
    localparam int SW = DW + LD;
    localparam int IW = clog2_min1(TIMEOUT);

    logic [LD-1:0] r_day_cnt;
    logic [SW-1:0] r_path_sum;
    logic [IW-1:0] r_idle_cnt;
    logic [DW-1:0] r_avg;
    logic          r_avg_valid;
    logic          r_timeout;

    logic [SW-1:0] w_sum_final;
    logic          w_accept;
    logic          w_stalled;
    logic          w_expire;

    assign w_sum_final = r_path_sum + SW'(i_sample);
    assign w_accept    = i_en && i_valid;
    assign o_path_done = w_accept && (r_day_cnt == LD'(DAY - 1));
    // Stall timing only runs inside a path; the gap between paths is unbounded.
    assign w_stalled   = i_en && !i_valid && (r_day_cnt != '0);
    assign w_expire    = w_stalled && (r_idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_day_cnt   <= '0;
            r_path_sum  <= '0;
            r_idle_cnt  <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_avg_valid <= o_path_done;
            r_timeout   <= w_expire;
            if (o_path_done) begin
                r_avg      <= DW'(w_sum_final >> LD);
                r_path_sum <= '0;
                r_day_cnt  <= '0;
                r_idle_cnt <= '0;
            end else if (w_accept) begin
                r_path_sum <= w_sum_final;
                r_day_cnt  <= r_day_cnt + 1'b1;
                r_idle_cnt <= '0;
            end else if (w_expire) begin
                r_path_sum <= '0;
                r_day_cnt  <= '0;
                r_idle_cnt <= '0;
            end else if (w_stalled) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign o_avg       = r_avg;
    assign o_avg_valid = r_avg_valid;
    assign o_timeout   = r_timeout;

endmodule

// File: rtl/asian_payoff_acc.sv
// Asian call Monte-Carlo pricer: averages each path, accumulates max(avg-K,0), emits the mean payoff.
module asian_payoff_acc
    import asian_payoff_acc_pkg::*;
#(
    parameter int DAY     = DAY_D,
    parameter int N_PATH  = N_PATH_D,
    parameter int DW      = DW_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic               clk,
    input  logic               rst,
    asian_payoff_acc_if.slave  bus
);
    localparam int LP = $clog2(N_PATH);
    localparam int AW = DW + LP;

    state_t        r_state;
    logic [DW-1:0] r_k;
    logic [AW-1:0] r_acc;
    logic [LP-1:0] r_path_cnt;
    logic [1:0]    r_flush_cnt;
    logic          r_busy;
    logic          r_price_valid;
    logic [DW-1:0] r_price;

    logic          w_en;
    logic          w_path_done;
    logic [DW-1:0] w_avg;
    logic          w_avg_valid;
    logic          w_timeout;
    logic [DW-1:0] w_payoff;

    // start has priority over a sample arriving in the same cycle.
    assign w_en = (r_state == S_COLLECT) && !bus.i_start;

    asian_payoff_acc_path_averager #(
        .DAY     (DAY),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) u_avg (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (bus.i_start),
        .i_en        (w_en),
        .i_valid     (bus.i_in_valid),
        .i_sample    (bus.i_in_sample),
        .o_path_done (w_path_done),
        .o_avg       (w_avg),
        .o_avg_valid (w_avg_valid),
        .o_timeout   (w_timeout)
    );

    assign w_payoff = (w_avg > r_k) ? (w_avg - r_k) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_acc         <= '0;
            r_path_cnt    <= '0;
            r_flush_cnt   <= '0;
            r_busy        <= 1'b0;
            r_price_valid <= 1'b0;
            r_price       <= '0;
        end else if (bus.i_start) begin
            r_state       <= S_COLLECT;
            r_k           <= bus.i_k;
            r_acc         <= '0;
            r_path_cnt    <= '0;
            r_flush_cnt   <= '0;
            r_busy        <= 1'b1;
            r_price_valid <= 1'b0;
            r_price       <= '0;
        end else begin
            if (w_avg_valid) begin
                r_acc      <= r_acc + AW'(w_payoff);
                r_path_cnt <= r_path_cnt + 1'b1;
            end
            case (r_state)
                S_COLLECT: begin
                    if (w_path_done && (r_path_cnt == LP'(N_PATH - 1))) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                    end
                end
                // Two cycles for the last avg and payoff to land in acc, then the output register.
                S_FLUSH: begin
                    if (r_flush_cnt == 2'd2) begin
                        r_state       <= S_DONE;
                        r_busy        <= 1'b0;
                        r_price_valid <= 1'b1;
                        r_price       <= DW'(r_acc >> LP);
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_resend      = w_timeout;
    assign bus.o_busy        = r_busy;
    assign bus.o_price_valid = r_price_valid;
    assign bus.o_price       = r_price;
    assign bus.o_state       = r_state;

endmodule

// File: tb/tb_asian_payoff_acc.sv
// Directed bench for asian_payoff_acc: expected prices queued by the driver, popped by per-DUT monitors.
module tb_asian_payoff_acc;
  import asian_payoff_acc_pkg::*;

  localparam int DW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  asian_payoff_acc_if #(.DW(DW)) bus4();
  asian_payoff_acc_if #(.DW(DW)) bus256();

  asian_payoff_acc #(.DAY(8), .N_PATH(4), .DW(DW), .TIMEOUT(16)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  asian_payoff_acc #(.DAY(8), .N_PATH(256), .DW(DW), .TIMEOUT(16)) dut256 (
    .clk (clk),
    .rst (rst),
    .bus (bus256)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  int last_cyc = 0;
  int resend_cnt4 = 0;
  logic [DW-1:0] exp_q4[$];
  logic [DW-1:0] exp_q256[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  logic pv4_q = 1'b0;
  always @(negedge clk) begin
    if (bus4.o_resend) resend_cnt4++;
    if (bus4.o_price_valid && !pv4_q) begin
      if (exp_q4.size() == 0) begin
        check("price4_unexpected", int'(bus4.o_price), -1);
      end else begin
        check("price4", int'(bus4.o_price), int'(exp_q4.pop_front()));
        check("latency4", cyc - last_cyc, 3);
        check("busy4_done", int'(bus4.o_busy), 0);
      end
    end
    pv4_q = bus4.o_price_valid;
  end

  logic pv256_q = 1'b0;
  always @(negedge clk) begin
    if (bus256.o_price_valid && !pv256_q) begin
      if (exp_q256.size() == 0) begin
        check("price256_unexpected", int'(bus256.o_price), -1);
      end else begin
        check("price256", int'(bus256.o_price), int'(exp_q256.pop_front()));
        check("latency256", cyc - last_cyc, 3);
      end
    end
    pv256_q = bus256.o_price_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic st, input logic [DW-1:0] kv,
                       input logic v, input logic [DW-1:0] s);
    if (sel == 0) begin
      bus4.i_start = st; bus4.i_k = kv; bus4.i_in_valid = v; bus4.i_in_sample = s;
    end else begin
      bus256.i_start = st; bus256.i_k = kv; bus256.i_in_valid = v; bus256.i_in_sample = s;
    end
    @(posedge clk);
    #1;
    if (v && !st) last_cyc = cyc;
    if (sel == 0) begin
      bus4.i_start = 1'b0; bus4.i_k = '0; bus4.i_in_valid = 1'b0; bus4.i_in_sample = '0;
    end else begin
      bus256.i_start = 1'b0; bus256.i_k = '0; bus256.i_in_valid = 1'b0; bus256.i_in_sample = '0;
    end
  endtask

  task automatic start_run(input int sel, input int kv);
    drive(sel, 1'b1, DW'(kv), 1'b0, '0);
  endtask

  task automatic send(input int sel, input int val);
    drive(sel, 1'b0, '0, 1'b1, DW'(val));
  endtask

  task automatic send_path(input int sel, input int val);
    for (int i = 0; i < 8; i++) send(sel, val);
  endtask

  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) drive(sel, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wait_price(input int sel, input int budget, input string name);
    int i;
    logic pv;
    i = 0;
    pv = (sel == 0) ? bus4.o_price_valid : bus256.o_price_valid;
    while (!pv && i < budget) begin
      @(posedge clk);
      #1;
      i++;
      pv = (sel == 0) ? bus4.o_price_valid : bus256.o_price_valid;
    end
    check({name, "_done"}, int'(pv), 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    check({name, "_popped"}, (sel == 0) ? exp_q4.size() : exp_q256.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus4.i_start = 1'b0; bus4.i_k = '0; bus4.i_in_valid = 1'b0; bus4.i_in_sample = '0;
    bus256.i_start = 1'b0; bus256.i_k = '0; bus256.i_in_valid = 1'b0; bus256.i_in_sample = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_resend", int'(bus4.o_resend), 0);
    check("rst_busy", int'(bus4.o_busy), 0);
    check("rst_pv", int'(bus4.o_price_valid), 0);
    check("rst_price", int'(bus4.o_price), 0);
    check("rst_state", int'(bus4.o_state), int'(S_IDLE));

    // Test 1: reset mid-run, then samples without start must be ignored
    start_run(0, 1024);
    for (int i = 0; i < 5; i++) send(0, 2048);
    rst = 1'b1;
    idle(0, 2);
    rst = 1'b0;
    check("midrst_busy", int'(bus4.o_busy), 0);
    check("midrst_pv", int'(bus4.o_price_valid), 0);
    check("midrst_price", int'(bus4.o_price), 0);
    check("midrst_state", int'(bus4.o_state), int'(S_IDLE));
    send_path(0, 2048);
    idle(0, 4);
    check("idle_ignores_state", int'(bus4.o_state), int'(S_IDLE));
    check("idle_ignores_busy", int'(bus4.o_busy), 0);

    // Test 2: K=1024, all 2048, no bubbles -> 1024
    start_run(0, 1024);
    check("start_busy", int'(bus4.o_busy), 1);
    check("start_state", int'(bus4.o_state), int'(S_COLLECT));
    exp_q4.push_back(12'd1024);
    for (int p = 0; p < 4; p++) send_path(0, 2048);
    wait_price(0, 20, "t2");
    send_path(0, 4095);
    check("done_hold_pv", int'(bus4.o_price_valid), 1);
    check("done_hold_price", int'(bus4.o_price), 1024);
    check("done_hold_state", int'(bus4.o_state), int'(S_DONE));

    // Test 3: avg == K -> payoff 0
    start_run(0, 4095);
    exp_q4.push_back(12'd0);
    for (int p = 0; p < 4; p++) send_path(0, 4095);
    wait_price(0, 20, "t3");

    // Test 3b: avg below K clamps to 0: payoffs 0,0,1000,1000 -> 500
    start_run(0, 2000);
    exp_q4.push_back(12'd500);
    send_path(0, 1000); send_path(0, 1000); send_path(0, 3000); send_path(0, 3000);
    wait_price(0, 20, "t3b");

    // Test 4: K=0, averages 100 (807>>3 truncates), 200, 300, 400 -> 250
    start_run(0, 0);
    exp_q4.push_back(12'd250);
    send(0, 107);
    for (int i = 0; i < 7; i++) send(0, 100);
    send_path(0, 200); send_path(0, 300); send_path(0, 400);
    wait_price(0, 20, "t4");

    // Test 5: stall between paths (no resend), 16-cycle stall in path 2 (resend), 15-cycle stall (no resend)
    resend_cnt4 = 0;
    start_run(0, 1024);
    exp_q4.push_back(12'd1024);
    send_path(0, 2048);
    idle(0, 20);
    check("gap_no_resend", resend_cnt4, 0);
    for (int i = 0; i < 3; i++) send(0, 4095);
    idle(0, 17);
    check("stall_resend", resend_cnt4, 1);
    for (int i = 0; i < 4; i++) send(0, 2048);
    idle(0, 15);
    for (int i = 0; i < 4; i++) send(0, 2048);
    check("stall15_no_resend", resend_cnt4, 1);
    send_path(0, 2048); send_path(0, 2048);
    wait_price(0, 20, "t5");
    check("t5_resend_total", resend_cnt4, 1);

    // Test 6: restart mid-run with new K; sample on the start cycle is dropped
    start_run(0, 1024);
    send_path(0, 4095); send_path(0, 4095);
    for (int i = 0; i < 3; i++) send(0, 4095);
    drive(0, 1'b1, 12'd0, 1'b1, 12'd4095);
    exp_q4.push_back(12'd25);
    send_path(0, 10); send_path(0, 20); send_path(0, 30); send_path(0, 40);
    wait_price(0, 20, "t6");

    // Test 7: N_PATH=256, K=1024, all 2048 -> 1024
    start_run(1, 1024);
    check("n256_busy", int'(bus256.o_busy), 1);
    exp_q256.push_back(12'd1024);
    for (int p = 0; p < 256; p++) send_path(1, 2048);
    wait_price(1, 20, "t7");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
